spi_slave: RTL and testbench

SPI responder (slave) for the other end of the team's SPI master link: it receives full-duplex frames from an external master on SCLK/CS_N/MOSI and returns data on MISO. All SPI inputs are oversampled and synchronised into the system clock domain; there is no logic clocked by SCLK. Transmit words enter through a one-word valid/ready buffer, and received words leave as a one-cycle valid pulse. Frames are MSB-first and DATA_W bits long, and CPOL/CPHA are fixed by parameter.

---
 rtl/spi_slave_if.sv | 29 ++
 rtl/spi_slave.sv | 138 +++++++++++++
 tb/tb_spi_slave.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Bus bundle between the SPI responder and its user: SPI pins plus the
// transmit buffer / receive stream handshakes.
interface spi_slave_if #(
  parameter int DATA_W = 16
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              underrun;
  logic              frame_err;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun, frame_err
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun, frame_err
  );
endinterface

// File: rtl/spi_slave.sv
// SPI responder with all pins oversampled into clk; fixed CPOL/CPHA, MSB-first
// frames of DATA_W bits, one-word transmit buffer and pulsed receive output.
module spi_slave #(
  parameter logic [1:0] MODE   = 2'b01,
  parameter int         DATA_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  spi_slave_if.slave bus
);
  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic            CPOL     = MODE[1];
  localparam logic            CPHA     = MODE[0];
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [0:0]      ST_IDLE   = 1'b0;
  localparam logic [0:0]      ST_ACTIVE = 1'b1;
  // Reset values chosen so no spurious edge is seen when reset releases.
  localparam logic [1:0]      PIN_RST   = {1'b1, CPOL};

  logic [1:0] pin_raw;
  logic [1:0] pin_sync;
  logic [1:0] pin_hist;
  logic [1:0] mosi_pipe_reg;
  logic       mosi_sync;

  assign pin_raw = {bus.cs_n, bus.sclk};

  // Channel 0 is sclk, channel 1 is cs_n: two sync flops plus an edge history flop.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic [2:0] pipe_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_reg <= {3{PIN_RST[gi]}};
        else        pipe_reg <= {pipe_reg[1:0], pin_raw[gi]};
      end
      assign pin_sync[gi] = pipe_reg[1];
      assign pin_hist[gi] = pipe_reg[2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_pipe_reg <= 2'b00;
    else        mosi_pipe_reg <= {mosi_pipe_reg[0], bus.mosi};
  end
  assign mosi_sync = mosi_pipe_reg[1];

  logic [0:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic [DATA_W-1:0] buf_data_reg;
  logic              buf_full_reg;
  logic              rx_valid_reg;
  logic              underrun_reg;
  logic              frame_err_reg;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, active, frame_done, load, accept;
  logic [DATA_W-1:0] rx_word;

  assign sclk_rise   = pin_sync[0] & ~pin_hist[0];
  assign sclk_fall   = ~pin_sync[0] & pin_hist[0];
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = ~pin_sync[1] & pin_hist[1];
  assign cs_rise     = pin_sync[1] & ~pin_hist[1];
  assign active      = (state_reg == ST_ACTIVE);
  assign rx_word     = {rx_shift_reg[DATA_W-2:0], mosi_sync};
  assign frame_done  = active & ~cs_rise & sample_edge & (cnt_reg == LAST_BIT);
  assign load        = (~active & cs_fall) | frame_done;
  assign accept      = bus.tx_valid & ~buf_full_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      rx_data_reg   <= '0;
      buf_data_reg  <= '0;
      buf_full_reg  <= 1'b0;
      rx_valid_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_valid_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
      frame_err_reg <= 1'b0;

      // Both decisions use the pre-edge buffer state, so a word accepted
      // alongside a load waits for the next frame.
      if (accept) begin
        buf_full_reg <= 1'b1;
        buf_data_reg <= bus.tx_data;
      end else if (load) begin
        buf_full_reg <= 1'b0;
      end

      if (load) begin
        tx_shift_reg <= buf_full_reg ? buf_data_reg : '0;
        underrun_reg <= ~buf_full_reg;
      end

      if (!active) begin
        cnt_reg <= '0;
        if (cs_fall) state_reg <= ST_ACTIVE;
      end else if (cs_rise) begin
        state_reg     <= ST_IDLE;
        cnt_reg       <= '0;
        frame_err_reg <= (cnt_reg != '0);
      end else if (sample_edge) begin
        rx_shift_reg <= rx_word;
        if (frame_done) begin
          rx_data_reg  <= rx_word;
          rx_valid_reg <= 1'b1;
          cnt_reg      <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else if (shift_edge && cnt_reg != '0) begin
        // Counter gate drops the CPHA=1 first leading edge and the CPHA=0 post-frame edge.
        tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign bus.miso      = active & tx_shift_reg[DATA_W-1];
  assign bus.miso_oe   = ~pin_sync[1];
  assign bus.tx_ready  = ~buf_full_reg;
  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.busy      = active;
  assign bus.underrun  = underrun_reg;
  assign bus.frame_err = frame_err_reg;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: three instances (MODE 01, 00, 11) driven by a
// behavioural SPI master, with per-scenario tasks checking inline.
module tb_spi_slave;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       sclk_v     = 3'b100;
  logic [2:0]       cs_n_v     = 3'b111;
  logic [2:0]       mosi_v     = 3'b000;
  logic [2:0]       tx_valid_v = 3'b000;
  logic [2:0][15:0] tx_data_v  = '0;

  wire [2:0]       miso_v, miso_oe_v, tx_ready_v, rx_valid_v, busy_v, underrun_v, frame_err_v;
  wire [2:0][15:0] rx_data_v;

  int checks = 0;
  int failures = 0;

  // Instance 0: MODE 01, instance 1: MODE 00, instance 2: MODE 11
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam logic [1:0] M = (gi == 0) ? 2'b01 : (gi == 1) ? 2'b00 : 2'b11;
    spi_slave_if #(.DATA_W(16)) bus_if ();
    assign bus_if.sclk     = sclk_v[gi];
    assign bus_if.cs_n     = cs_n_v[gi];
    assign bus_if.mosi     = mosi_v[gi];
    assign bus_if.tx_valid = tx_valid_v[gi];
    assign bus_if.tx_data  = tx_data_v[gi];
    assign miso_v[gi]      = bus_if.miso;
    assign miso_oe_v[gi]   = bus_if.miso_oe;
    assign tx_ready_v[gi]  = bus_if.tx_ready;
    assign rx_valid_v[gi]  = bus_if.rx_valid;
    assign busy_v[gi]      = bus_if.busy;
    assign underrun_v[gi]  = bus_if.underrun;
    assign frame_err_v[gi] = bus_if.frame_err;
    assign rx_data_v[gi]   = bus_if.rx_data;
    spi_slave #(.MODE(M), .DATA_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));
  end

  int          rxv_cnt [3] = '{0, 0, 0};
  int          ur_cnt  [3] = '{0, 0, 0};
  int          fe_cnt  [3] = '{0, 0, 0};
  logic [15:0] rx_last [3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] rx_prev [3] = '{16'h0, 16'h0, 16'h0};

  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      if (rx_valid_v[m] === 1'b1) begin
        rxv_cnt[m] <= rxv_cnt[m] + 1;
        rx_prev[m] <= rx_last[m];
        rx_last[m] <= rx_data_v[m];
      end
      if (underrun_v[m] === 1'b1) ur_cnt[m] <= ur_cnt[m] + 1;
      if (frame_err_v[m] === 1'b1) fe_cnt[m] <= fe_cnt[m] + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int m, input logic [15:0] w);
    int n;
    n = 0;
    while (tx_ready_v[m] !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    if (tx_ready_v[m] !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL push_timeout inst=%0d: tx_ready=%b required 1", m, tx_ready_v[m]);
    end else begin
      tx_data_v[m]  = w;
      tx_valid_v[m] = 1'b1;
      tick(1);
      tx_valid_v[m] = 1'b0;
    end
  endtask

  task automatic cs_assert(input int m);
    cs_n_v[m] = 1'b0;
    tick(6);
  endtask

  task automatic cs_release(input int m);
    cs_n_v[m] = 1'b1;
    tick(6);
  endtask

  // Master side of nbits bit periods; miso is captured at each master sample
  // edge and again two cycles later to check it held steady.
  task automatic xfer(input int m, input logic [15:0] w, input int nbits,
                      output logic [15:0] r, output int unstable);
    logic cpol, cpha, a, b;
    cpol = (m == 2);
    cpha = (m != 1);
    r = '0;
    unstable = 0;
    for (int i = 15; i > 15 - nbits; i--) begin
      if (!cpha) begin
        mosi_v[m] = w[i];
        tick(HALF);
        a = miso_v[m];
        sclk_v[m] = ~cpol;
        tick(2);
        b = miso_v[m];
        tick(HALF - 2);
        sclk_v[m] = cpol;
      end else begin
        sclk_v[m] = ~cpol;
        mosi_v[m] = w[i];
        tick(HALF);
        a = miso_v[m];
        sclk_v[m] = cpol;
        tick(2);
        b = miso_v[m];
        tick(HALF - 2);
      end
      r[i] = a;
      if (a !== b) unstable++;
    end
    if (!cpha) tick(HALF);
  endtask

  task automatic test_reset();
    tick(2);
    for (int m = 0; m < 3; m++) begin
      checks++;
      if ({miso_v[m], miso_oe_v[m], tx_ready_v[m], rx_valid_v[m], busy_v[m], underrun_v[m], frame_err_v[m]} !== 7'b0010000) begin
        failures++;
        $display("FAIL reset_flags inst=%0d: got %b required 0010000", m,
                 {miso_v[m], miso_oe_v[m], tx_ready_v[m], rx_valid_v[m], busy_v[m], underrun_v[m], frame_err_v[m]});
      end
      checks++;
      if (rx_data_v[m] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_rx_data inst=%0d: got %h required 0000", m, rx_data_v[m]);
      end
    end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_single(input int m);
    logic [15:0] got;
    int unst, rv0, ur0, fe0;
    rv0 = rxv_cnt[m]; ur0 = ur_cnt[m]; fe0 = fe_cnt[m];
    push(m, 16'h3C5A);
    cs_assert(m);
    checks++;
    if (ur_cnt[m] - ur0 !== 0) begin
      failures++;
      $display("FAIL single_underrun inst=%0d: got %0d required 0", m, ur_cnt[m] - ur0);
    end
    xfer(m, 16'hA5C3, 16, got, unst);
    cs_release(m);
    checks++;
    if (got !== 16'h3C5A) begin
      failures++;
      $display("FAIL single_miso inst=%0d: got %h required 3c5a", m, got);
    end
    checks++;
    if (rx_data_v[m] !== 16'hA5C3) begin
      failures++;
      $display("FAIL single_rx_data inst=%0d: got %h required a5c3", m, rx_data_v[m]);
    end
    checks++;
    if (rxv_cnt[m] - rv0 !== 1) begin
      failures++;
      $display("FAIL single_rx_valid inst=%0d: got %0d pulses required 1", m, rxv_cnt[m] - rv0);
    end
    checks++;
    if (unst !== 0) begin
      failures++;
      $display("FAIL single_miso_stable inst=%0d: got %0d unstable bits required 0", m, unst);
    end
    checks++;
    if (fe_cnt[m] - fe0 !== 0) begin
      failures++;
      $display("FAIL single_frame_err inst=%0d: got %0d required 0", m, fe_cnt[m] - fe0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got1, got2;
    int unst1, unst2, rv0;
    rv0 = rxv_cnt[0];
    push(0, 16'h1234);
    cs_assert(0);
    push(0, 16'hBEEF);
    xfer(0, 16'h0001, 16, got1, unst1);
    xfer(0, 16'hFFFF, 16, got2, unst2);
    cs_release(0);
    checks++;
    if (got1 !== 16'h1234) begin
      failures++;
      $display("FAIL b2b_miso_1: got %h required 1234", got1);
    end
    checks++;
    if (got2 !== 16'hBEEF) begin
      failures++;
      $display("FAIL b2b_miso_2: got %h required beef", got2);
    end
    checks++;
    if (rxv_cnt[0] - rv0 !== 2) begin
      failures++;
      $display("FAIL b2b_rx_valid: got %0d pulses required 2", rxv_cnt[0] - rv0);
    end
    checks++;
    if (rx_prev[0] !== 16'h0001) begin
      failures++;
      $display("FAIL b2b_rx_1: got %h required 0001", rx_prev[0]);
    end
    checks++;
    if (rx_last[0] !== 16'hFFFF) begin
      failures++;
      $display("FAIL b2b_rx_2: got %h required ffff", rx_last[0]);
    end
  endtask

  task automatic test_underrun();
    logic [15:0] got;
    int unst, ur0;
    ur0 = ur_cnt[0];
    cs_assert(0);
    checks++;
    if (ur_cnt[0] - ur0 !== 1) begin
      failures++;
      $display("FAIL underrun_start: got %0d pulses required 1", ur_cnt[0] - ur0);
    end
    // Refill so the end-of-frame reload finds a word and raises no second underrun.
    push(0, 16'h7777);
    xfer(0, 16'h6B6B, 16, got, unst);
    cs_release(0);
    checks++;
    if (got !== 16'h0000) begin
      failures++;
      $display("FAIL underrun_miso: got %h required 0000", got);
    end
    checks++;
    if (rx_data_v[0] !== 16'h6B6B) begin
      failures++;
      $display("FAIL underrun_rx_data: got %h required 6b6b", rx_data_v[0]);
    end
    checks++;
    if (ur_cnt[0] - ur0 !== 1) begin
      failures++;
      $display("FAIL underrun_total: got %0d pulses required 1", ur_cnt[0] - ur0);
    end
  endtask

  task automatic test_abort();
    logic [15:0] got;
    int unst, rv0, fe0;
    rv0 = rxv_cnt[0]; fe0 = fe_cnt[0];
    push(0, 16'hABCD);
    cs_assert(0);
    xfer(0, 16'h1357, 7, got, unst);
    checks++;
    if (busy_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy_mid: got %b required 1", busy_v[0]);
    end
    cs_release(0);
    checks++;
    if (fe_cnt[0] - fe0 !== 1) begin
      failures++;
      $display("FAIL abort_frame_err: got %0d pulses required 1", fe_cnt[0] - fe0);
    end
    checks++;
    if (rxv_cnt[0] - rv0 !== 0) begin
      failures++;
      $display("FAIL abort_rx_valid: got %0d pulses required 0", rxv_cnt[0] - rv0);
    end
    checks++;
    if (rx_data_v[0] !== 16'h6B6B) begin
      failures++;
      $display("FAIL abort_rx_held: got %h required 6b6b", rx_data_v[0]);
    end
    checks++;
    if (busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy_idle: got %b required 0", busy_v[0]);
    end
    push(0, 16'h0F0F);
    cs_assert(0);
    xfer(0, 16'h8421, 16, got, unst);
    cs_release(0);
    checks++;
    if (got !== 16'h0F0F) begin
      failures++;
      $display("FAIL abort_next_miso: got %h required 0f0f", got);
    end
    checks++;
    if (rx_data_v[0] !== 16'h8421) begin
      failures++;
      $display("FAIL abort_next_rx: got %h required 8421", rx_data_v[0]);
    end
    checks++;
    if (fe_cnt[0] - fe0 !== 1) begin
      failures++;
      $display("FAIL abort_next_frame_err: got %0d pulses required 1", fe_cnt[0] - fe0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] got;
    int unst;
    push(0, 16'hFFFF);
    cs_assert(0);
    push(0, 16'h2468);
    xfer(0, 16'h5555, 9, got, unst);
    checks++;
    if ({busy_v[0], miso_v[0], tx_ready_v[0]} !== 3'b110) begin
      failures++;
      $display("FAIL rstmid_before: busy/miso/tx_ready got %b required 110",
               {busy_v[0], miso_v[0], tx_ready_v[0]});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({miso_v[0], miso_oe_v[0], tx_ready_v[0], rx_valid_v[0], busy_v[0], underrun_v[0], frame_err_v[0]} !== 7'b0010000) begin
      failures++;
      $display("FAIL rstmid_flags: got %b required 0010000",
               {miso_v[0], miso_oe_v[0], tx_ready_v[0], rx_valid_v[0], busy_v[0], underrun_v[0], frame_err_v[0]});
    end
    checks++;
    if (rx_data_v[0] !== 16'h0000) begin
      failures++;
      $display("FAIL rstmid_rx_data: got %h required 0000", rx_data_v[0]);
    end
    cs_n_v[0] = 1'b1;
    sclk_v[0] = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    push(0, 16'h1111);
    cs_assert(0);
    xfer(0, 16'h2222, 16, got, unst);
    cs_release(0);
    checks++;
    if (got !== 16'h1111) begin
      failures++;
      $display("FAIL rstmid_next_miso: got %h required 1111", got);
    end
    checks++;
    if (rx_data_v[0] !== 16'h2222) begin
      failures++;
      $display("FAIL rstmid_next_rx: got %h required 2222", rx_data_v[0]);
    end
  endtask

  initial begin
    test_reset();
    for (int m = 0; m < 3; m++) test_single(m);
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end
endmodule
